// File: rtl/sub_shift_rows.sv
// AES SubBytes + ShiftRows stage: substitutes one column per cycle into a work
// register and presents the row-rotated result with a valid/ready handshake.
module sub_shift_rows (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic [3:0]   in_round,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic [3:0]   out_round
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t         state_q;
   logic [1:0]     col_q;
   logic [127:0]   work_q;
   logic [127:0]   work_d;
   logic [3:0]     tag_q;
   logic           out_valid_q;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = '0;
      aa = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as required.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = x;
      for (int unsigned i = 1; i < 8; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
               ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   always_comb begin
      logic [31:0] col_word;
      work_d   = work_q;
      col_word = work_q[127 - 32*col_q -: 32];
      work_d[127 - 32*col_q -: 32] = {sbox(col_word[31:24]), sbox(col_word[23:16]),
                                      sbox(col_word[15:8]),  sbox(col_word[7:0])};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         col_q       <= '0;
         work_q      <= '0;
         tag_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  work_q  <= in_state;
                  tag_q   <= in_round;
                  col_q   <= '0;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               work_q <= work_d;
               col_q  <= col_q + 2'd1;
               if (col_q == 2'd3) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  if (in_valid) begin
                     work_q  <= in_state;
                     tag_q   <= in_round;
                     col_q   <= '0;
                     state_q <= BUSY;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign out_valid = out_valid_q;
   assign out_round = tag_q;

   // Row r of the result takes its byte from column (c + r) mod 4.
   always_comb begin
      out_state = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            out_state[127 - 8*(r + 4*c) -: 8] = work_q[127 - 8*(r + 4*((c + r) % 4)) -: 8];
         end
      end
   end

endmodule
